apb_bcd_sequencer: RTL and testbench
====================================

APB_BCD_SEQUENCER -- requirements
Module: apb_bcd_sequencer

Interface
REQ-001 Parameter DEPTH, default 4, is the command FIFO depth (power of two, 2..16).
REQ-002 Parameter TIMEOUT, default 15, is the maximum number of cycles a transfer may spend in SETUP plus ACCESS before it is aborted.
REQ-003 PCLK  in  1  single clock; all state updates on the rising edge.
REQ-004 PRESET  in  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 cmd_valid  in  1  upstream command offered.
REQ-006 cmd_ready  out  1  FIFO not full; a push occurs on cmd_valid & cmd_ready.
REQ-007 cmd_write  in  1  PWRITE value for the command.
REQ-008 cmd_f  in  2  slave function select for the command.
REQ-009 cmd_addr  in  32  PADDR value for the command.
REQ-010 cmd_data  in  32  PDATA value for the command.
REQ-011 PSEL, transfer, PWRITE  out  1 each  APB request controls driven to master and slave.
REQ-012 PADDR, PDATA  out  32 each  APB address and data driven to the master.
REQ-013 f  out  2  function select driven to the slave.
REQ-014 PENABLE  in  1  access phase indication from the master.
REQ-015 PREADY  in  1  completion from the slave.
REQ-016 PRDATA1  in  32  slave result.
REQ-017 rsp_valid  out  1  response held; rsp_ready  in  1  a pop occurs on rsp_valid & rsp_ready.
REQ-018 rsp_data  out  32  captured PRDATA1; rsp_f  out  2  f of the completed command; rsp_err  out  1  timeout flag.

Function
REQ-019 FSM states SHALL be IDLE, SETUP, ACCESS and GAP.
REQ-020 IDLE -> SETUP SHALL occur when the FIFO is non-empty and rsp_valid=0; on that edge the head entry is popped and its fields are registered onto PWRITE, PADDR, PDATA and f, and PSEL=1 and transfer=1 are set.
REQ-021 SETUP -> ACCESS SHALL occur on the first cycle in which PENABLE=1.
REQ-022 ACCESS -> GAP SHALL occur on the first cycle in which PREADY=1; on that edge PRDATA1 is captured into rsp_data, the current f is copied to rsp_f, rsp_err is set to 0 and rsp_valid is set to 1.
REQ-023 GAP SHALL last exactly one cycle with PSEL=0 and transfer=0, then return to IDLE.
REQ-024 PSEL SHALL be 1 only in SETUP and ACCESS; PWRITE, PADDR, PDATA and f SHALL remain stable from entry to SETUP until entry to GAP.
REQ-025 A 4-bit timeout counter SHALL clear on entry to SETUP and increment every cycle in SETUP or ACCESS.
REQ-026 When the counter reaches TIMEOUT without PREADY=1, the FSM SHALL go to GAP with rsp_valid=1, rsp_err=1 and rsp_data=0; if PREADY=1 arrives on that same cycle, completion wins and rsp_err=0.
REQ-027 Minimum latency from push into an empty FIFO to rsp_valid SHALL be 4 cycles when the slave has zero wait states (push, SETUP, ACCESS, capture).
REQ-028 The FIFO SHALL be circular with wrap-around pointers and a count; a push and a pop in the same cycle leave the count unchanged, including when the FIFO is full.
REQ-029 cmd_ready SHALL be 0 when count = DEPTH; a push while full SHALL be ignored.
REQ-030 rsp_valid SHALL clear on rsp_valid & rsp_ready; no new command issues while rsp_valid=1 (single response slot, no loss).
REQ-031 The FIFO pop in REQ-020 and rsp_ready draining the slot in the same cycle SHALL NOT both occur, because IDLE requires rsp_valid=0 at the start of the cycle.

Reset
REQ-032 PRESET=0 SHALL immediately force: FSM to IDLE; FIFO pointers, count and timeout counter to 0; PSEL=0, transfer=0, PWRITE=0, PADDR=0, PDATA=0, f=0; rsp_valid=0, rsp_data=0, rsp_f=0, rsp_err=0; cmd_ready=0.
REQ-033 After PRESET rises, cmd_ready SHALL be 1 from the first clock edge onward; a reset mid-transfer SHALL discard the transfer and all queued commands with no response.

Verification
REQ-034 Push {write=1, f=00, addr=0x0, data=0x00000309} with a zero-wait slave -> PSEL high for 2 cycles, then one GAP cycle, rsp_valid after 4 cycles, rsp_f=00, rsp_err=0.
REQ-035 Push three commands back-to-back (addr 0x4, 0x8 and 0xC with f = 01, 10 and 11) with rsp_ready=1 -> three responses in order with rsp_f = 01, 10 and 11, and PSEL low for at least one cycle between transfers.
REQ-036 With rsp_ready=0, push DEPTH+2 commands -> one response held, FIFO full with cmd_ready=0, extra pushes dropped; raising rsp_ready drains the remaining entries in order.
REQ-037 With PREADY tied to 0 -> after 15 cycles in SETUP+ACCESS, rsp_valid=1, rsp_err=1 and rsp_data=0, and the next command then proceeds.
REQ-038 Assert PRESET=0 during ACCESS with 2 commands queued -> outputs reach reset values asynchronously, no response is produced, and the FIFO is empty after reset.
REQ-039 Push and pop at the same time while the FIFO is full with wrapped pointers -> count stays at DEPTH and entry order is preserved.

Source files
------------

// File: rtl/apb_bcd_sequencer.sv
// apb_bcd_sequencer: queues APB commands in a small circular FIFO and issues
// them one at a time through a SETUP/ACCESS/GAP handshake. Each finished
// transfer lands in a single response slot. The slot holds either the
// captured slave data or a timeout flag.
module apb_bcd_sequencer #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 15
) (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [1:0]  cmd_f,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_data,
  output logic        PSEL,
  output logic        transfer,
  output logic        PWRITE,
  output logic [31:0] PADDR,
  output logic [31:0] PDATA,
  output logic [1:0]  f,
  input  logic        PENABLE,
  input  logic        PREADY,
  input  logic [31:0] PRDATA1,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic [1:0]  rsp_f,
  output logic        rsp_err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, GAP} state_t;

  typedef struct packed {
    logic        write;
    logic [1:0]  fsel;
    logic [31:0] addr;
    logic [31:0] data;
  } cmd_t;

  cmd_t             mem [DEPTH];
  cmd_t             head;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             run;
  logic             push;
  logic             pop;
  logic [3:0]       tmo;
  logic             tmo_hit;
  state_t           state;

  // run goes high on the first edge after reset so cmd_ready stays low while
  // reset is held and rises one edge later.
  assign cmd_ready = run & (count != CNT_W'(DEPTH));
  assign push      = cmd_valid & cmd_ready;
  // A new command leaves the FIFO only when the response slot is already empty.
  assign pop       = (state == IDLE) & (count != '0) & ~rsp_valid;
  assign head      = mem[rd_ptr];
  // The abort fires on the edge where the counter would reach TIMEOUT.
  assign tmo_hit   = (tmo + 4'd1) == 4'(TIMEOUT);

  // FIFO storage. This is data only, so it has no reset.
  always_ff @(posedge PCLK) begin
    if (push) mem[wr_ptr] <= '{write: cmd_write, fsel: cmd_f, addr: cmd_addr, data: cmd_data};
  end

  // FIFO pointers and occupancy. The pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      run    <= 1'b0;
    end else begin
      run <= 1'b1;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Transfer FSM with registered APB outputs, timeout counter and response slot.
  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) begin
      state     <= IDLE;
      tmo       <= 4'd0;
      PSEL      <= 1'b0;
      transfer  <= 1'b0;
      PWRITE    <= 1'b0;
      PADDR     <= 32'd0;
      PDATA     <= 32'd0;
      f         <= 2'd0;
      rsp_valid <= 1'b0;
      rsp_data  <= 32'd0;
      rsp_f     <= 2'd0;
      rsp_err   <= 1'b0;
    end else begin
      if (rsp_valid && rsp_ready) rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (pop) begin
            state    <= SETUP;
            tmo      <= 4'd0;
            PSEL     <= 1'b1;
            transfer <= 1'b1;
            PWRITE   <= head.write;
            PADDR    <= head.addr;
            PDATA    <= head.data;
            f        <= head.fsel;
          end
        end
        SETUP: begin
          tmo <= tmo + 4'd1;
          if (tmo_hit) begin
            state     <= GAP;
            PSEL      <= 1'b0;
            transfer  <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_data  <= 32'd0;
            rsp_f     <= f;
          end else if (PENABLE) begin
            state <= ACCESS;
          end
        end
        ACCESS: begin
          tmo <= tmo + 4'd1;
          // A completion on the final timeout cycle takes priority over the abort.
          if (PREADY) begin
            state     <= GAP;
            PSEL      <= 1'b0;
            transfer  <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b0;
            rsp_data  <= PRDATA1;
            rsp_f     <= f;
          end else if (tmo_hit) begin
            state     <= GAP;
            PSEL      <= 1'b0;
            transfer  <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_data  <= 32'd0;
            rsp_f     <= f;
          end
        end
        GAP: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_bcd_sequencer.sv
// Directed bench for apb_bcd_sequencer. The master side drives PENABLE as a
// copy of PSEL. The slave answers with PRDATA1 = PADDR + PDATA.
module tb_apb_bcd_sequencer;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [1:0]  cmd_f;
  logic [31:0] cmd_addr, cmd_data;
  logic        psel, transfer, pwrite;
  logic [31:0] paddr, pdata;
  logic [1:0]  fsel;
  logic        penable, pready;
  logic [31:0] prdata1;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_data;
  logic [1:0]  rsp_f;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] q_data [$];
  logic [1:0]  q_f [$];
  logic        q_err [$];
  int          psel_rises = 0;
  int          psel_hi = 0;
  logic        psel_prev = 1'b0;

  always #5 clk = ~clk;

  assign penable = psel;
  assign prdata1 = paddr + pdata;

  apb_bcd_sequencer #(.DEPTH(DEPTH), .TIMEOUT(15)) dut (
    .PCLK(clk), .PRESET(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_f(cmd_f), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .PSEL(psel), .transfer(transfer), .PWRITE(pwrite),
    .PADDR(paddr), .PDATA(pdata), .f(fsel),
    .PENABLE(penable), .PREADY(pready), .PRDATA1(prdata1),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_f(rsp_f), .rsp_err(rsp_err)
  );

  // Response and PSEL monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (rsp_valid && rsp_ready) begin
      q_data.push_back(rsp_data);
      q_f.push_back(rsp_f);
      q_err.push_back(rsp_err);
    end
    if (psel) psel_hi++;
    if (psel && !psel_prev) psel_rises++;
    psel_prev = psel;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_cmd(input logic w, input logic [1:0] ff, input logic [31:0] a, input logic [31:0] d);
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_f     = ff;
    cmd_addr  = a;
    cmd_data  = d;
  endtask

  task automatic wait_q(input string tag, input int target, input int budget);
    for (int n = 0; n < budget && q_data.size() < target; n++) step();
    check(tag, 32'(q_data.size()), 32'(target));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int qb, rb, hb, k;
    logic [31:0] exp_d;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_f = 2'd0; cmd_addr = 32'd0; cmd_data = 32'd0;
    pready = 1'b1; rsp_ready = 1'b0;

    // Reset state while reset is held.
    #2;
    check("rst_psel", 32'(psel), 32'h0);
    check("rst_cmd_ready", 32'(cmd_ready), 32'h0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    check("rst_paddr", paddr, 32'h0);
    #9 rst_n = 1'b1;
    step();
    check("ready_after_reset", 32'(cmd_ready), 32'h1);

    // Single write with a zero-wait slave.
    drive_cmd(1'b1, 2'd0, 32'h0, 32'h309); step(); cmd_valid = 1'b0;
    check("t1_idle_psel", 32'(psel), 32'h0);
    step();
    check("t1_setup_psel", 32'(psel), 32'h1);
    check("t1_setup_transfer", 32'(transfer), 32'h1);
    check("t1_pwrite", 32'(pwrite), 32'h1);
    check("t1_pdata", pdata, 32'h309);
    check("t1_paddr", paddr, 32'h0);
    step();
    check("t1_access_psel", 32'(psel), 32'h1);
    check("t1_access_rsp_valid", 32'(rsp_valid), 32'h0);
    step();
    check("t1_rsp_valid", 32'(rsp_valid), 32'h1);
    check("t1_gap_psel", 32'(psel), 32'h0);
    check("t1_gap_transfer", 32'(transfer), 32'h0);
    check("t1_rsp_data", rsp_data, 32'h309);
    check("t1_rsp_f", 32'(rsp_f), 32'h0);
    check("t1_rsp_err", 32'(rsp_err), 32'h0);
    step();
    check("t1_rsp_held", 32'(rsp_valid), 32'h1);
    check("t1_no_reissue", 32'(psel), 32'h0);
    rsp_ready = 1'b1; step(); rsp_ready = 1'b0;
    check("t1_rsp_cleared", 32'(rsp_valid), 32'h0);

    // Three back-to-back commands with rsp_ready held high.
    rsp_ready = 1'b1; qb = q_data.size(); rb = psel_rises; hb = psel_hi;
    drive_cmd(1'b0, 2'd1, 32'h4, 32'h11); step();
    drive_cmd(1'b0, 2'd2, 32'h8, 32'h22); step();
    drive_cmd(1'b0, 2'd3, 32'hC, 32'h33); step();
    cmd_valid = 1'b0;
    wait_q("t2_rsp_count", qb + 3, 40);
    for (int i = 0; i < 3; i++) begin
      check("t2_rsp_f", 32'(q_f[qb+i]), 32'(i + 1));
      check("t2_rsp_data", q_data[qb+i], 32'(32'h15 * (i + 1)));
      check("t2_rsp_err", 32'(q_err[qb+i]), 32'h0);
    end
    check("t2_psel_rises", 32'(psel_rises - rb), 32'd3);
    check("t2_psel_hi_cycles", 32'(psel_hi - hb), 32'd6);

    // DEPTH+2 pushes while the response slot is held.
    rsp_ready = 1'b0; qb = q_data.size();
    for (int i = 0; i < DEPTH + 2; i++) begin
      drive_cmd(i[0], i[1:0], 32'(32'h100 + 4 * i), 32'(32'h1000 + i));
      step();
    end
    cmd_valid = 1'b0;
    check("t3_full_ready", 32'(cmd_ready), 32'h0);
    check("t3_rsp_held", 32'(rsp_valid), 32'h1);
    check("t3_rsp_data", rsp_data, 32'h1100);
    repeat (3) step();
    check("t3_still_full", 32'(cmd_ready), 32'h0);
    check("t3_still_held", 32'(rsp_valid), 32'h1);
    rsp_ready = 1'b1;
    wait_q("t3_rsp_count", qb + 5, 60);
    for (int i = 0; i < 5; i++) begin
      check("t3_rsp_f", 32'(q_f[qb+i]), 32'(i % 4));
      check("t3_rsp_data", q_data[qb+i], 32'(32'h1100 + 5 * i));
    end
    repeat (10) step();
    check("t3_dropped", 32'(q_data.size()), 32'(qb + 5));

    // Full FIFO with wrapped pointers, then refill while draining.
    rsp_ready = 1'b0; qb = q_data.size();
    for (int i = 0; i < 5; i++) begin
      drive_cmd(1'b1, i[1:0], 32'(32'h200 + 4 * i), 32'(32'h2000 + i));
      step();
    end
    cmd_valid = 1'b0;
    check("t4_full_ready", 32'(cmd_ready), 32'h0);
    drive_cmd(1'b0, 2'd3, 32'h300, 32'h3000);
    rsp_ready = 1'b1;
    k = 0;
    while (!cmd_ready && k < 10) begin step(); k++; end
    check("t4_ready_rise", 32'(cmd_ready), 32'h1);
    step(); cmd_valid = 1'b0;
    check("t4_full_again", 32'(cmd_ready), 32'h0);
    wait_q("t4_rsp_count", qb + 6, 80);
    for (int i = 0; i < 6; i++) begin
      exp_d = (i < 5) ? 32'(32'h2200 + 5 * i) : 32'h3300;
      check("t4_rsp_data", q_data[qb+i], exp_d);
      check("t4_rsp_f", 32'(q_f[qb+i]), (i < 5) ? 32'(i % 4) : 32'd3);
    end
    rsp_ready = 1'b0;

    // Timeout with PREADY held low, then the next command proceeds.
    pready = 1'b0; qb = q_data.size();
    drive_cmd(1'b0, 2'd2, 32'h40, 32'h5); step();
    drive_cmd(1'b1, 2'd1, 32'h44, 32'h6); step();
    cmd_valid = 1'b0;
    repeat (14) step();
    check("t5_psel_before_abort", 32'(psel), 32'h1);
    check("t5_no_rsp_yet", 32'(rsp_valid), 32'h0);
    step();
    check("t5_rsp_valid", 32'(rsp_valid), 32'h1);
    check("t5_rsp_err", 32'(rsp_err), 32'h1);
    check("t5_rsp_data", rsp_data, 32'h0);
    check("t5_rsp_f", 32'(rsp_f), 32'h2);
    check("t5_gap_psel", 32'(psel), 32'h0);
    pready = 1'b1; rsp_ready = 1'b1;
    wait_q("t5_rsp_count", qb + 2, 30);
    check("t5_first_err", 32'(q_err[qb]), 32'h1);
    check("t5_next_err", 32'(q_err[qb+1]), 32'h0);
    check("t5_next_data", q_data[qb+1], 32'h4A);
    check("t5_next_f", 32'(q_f[qb+1]), 32'h1);

    // PREADY arriving on the final timeout cycle wins.
    pready = 1'b0; qb = q_data.size();
    drive_cmd(1'b0, 2'd3, 32'h80, 32'h8); step(); cmd_valid = 1'b0;
    repeat (14) step();
    check("t6_psel_late", 32'(psel), 32'h1);
    step();
    pready = 1'b1;
    check("t6_psel_last", 32'(psel), 32'h1);
    step();
    check("t6_rsp_valid", 32'(rsp_valid), 32'h1);
    check("t6_rsp_err", 32'(rsp_err), 32'h0);
    check("t6_rsp_data", rsp_data, 32'h88);
    wait_q("t6_rsp_count", qb + 1, 10);

    // Reset during ACCESS with two commands queued.
    pready = 1'b0; rsp_ready = 1'b1; qb = q_data.size();
    drive_cmd(1'b1, 2'd1, 32'h400, 32'h1); step();
    drive_cmd(1'b1, 2'd2, 32'h404, 32'h2); step();
    drive_cmd(1'b1, 2'd3, 32'h408, 32'h3); step();
    cmd_valid = 1'b0;
    step();
    check("t7_in_access", 32'(psel), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("t7_rst_psel", 32'(psel), 32'h0);
    check("t7_rst_transfer", 32'(transfer), 32'h0);
    check("t7_rst_paddr", paddr, 32'h0);
    check("t7_rst_pdata", pdata, 32'h0);
    check("t7_rst_f", 32'(fsel), 32'h0);
    check("t7_rst_cmd_ready", 32'(cmd_ready), 32'h0);
    check("t7_rst_rsp_valid", 32'(rsp_valid), 32'h0);
    #3 rst_n = 1'b1;
    pready = 1'b1;
    rb = psel_rises;
    step();
    check("t7_ready_after_reset", 32'(cmd_ready), 32'h1);
    repeat (20) step();
    check("t7_no_transfer", 32'(psel_rises - rb), 32'd0);
    check("t7_no_response", 32'(q_data.size()), 32'(qb));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
